// File: rtl/zeroriscy_bnn_seq.sv
// zeroriscy_bnn_seq: autonomous BNN command initiator for one binarized dense layer.
// Optional perf_cycles_o/perf_stall_o counters exist only when BNN_SEQ_PERF_EN is defined.
module zeroriscy_bnn_seq #(
   parameter int IN_DEPTH = 64,
   parameter int IN_AW    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_we_i,
   input  logic [IN_AW-1:0] in_waddr_i,
   input  logic [31:0]      in_wdata_i,
   input  logic             start_i,
   input  logic [7:0]       in_words_i,
   input  logic [3:0]       pool_n_i,
   input  logic [7:0]       out_blocks_i,
   input  logic [15:0]      param_base_i,
   input  logic [15:0]      norm_base_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             res_valid_o,
   output logic [7:0]       res_idx_o,
   output logic [31:0]      res_data_o,
   output logic             bnn_en_o,
   output logic [2:0]       bnn_operator_o,
   output logic [31:0]      bnn_addr_o,
   output logic [31:0]      bnn_data_o,
   input  logic [31:0]      bnn_result_i,
   input  logic             bnn_ready_i
`ifdef BNN_SEQ_PERF_EN
   ,
   output logic [31:0]      perf_cycles_o,
   output logic [31:0]      perf_stall_o
`endif
);
   typedef enum logic [2:0] {S_IDLE, S_INI, S_ACC, S_POOL, S_NORM, S_ACTIV, S_WAITR, S_FIN} state_t;
   state_t st, nxt;
   logic [31:0] mem [IN_DEPTH];
   logic [7:0] w_n, b_n, w_q, b_q;
   logic [3:0] p_n, p_q;
   logic [15:0] pb_q, nb_q, acc_addr;
   logic [IN_AW-1:0] rd_addr;
   logic skip_q, zero, xfer, start_ok, cap, last_w, last_p, last_b;
   assign zero = w_n == 8'd0 || p_n == 4'd0 || b_n == 8'd0;
   assign start_ok = start_i && (st == S_IDLE || st == S_FIN);
   assign xfer = bnn_en_o && bnn_ready_i;
   assign cap = st == S_WAITR && !skip_q && bnn_ready_i;
   assign last_w = {1'b0, w_q} + 9'd1 >= {1'b0, w_n};
   assign last_p = {1'b0, p_q} + 5'd1 >= {1'b0, p_n};
   assign last_b = {1'b0, b_q} + 9'd1 >= {1'b0, b_n};
   assign rd_addr = IN_AW'(p_q) * IN_AW'(w_n) + IN_AW'(w_q);
   assign acc_addr = pb_q + {8'd0, b_q} * {8'd0, w_n} + {8'd0, w_q};
   assign busy_o = st != S_IDLE && st != S_FIN;
   assign done_o = st == S_FIN;
   always_ff @(posedge clk) begin
      if (in_we_i) mem[in_waddr_i] <= in_wdata_i;
   end
   always_ff @(posedge clk) begin
      if (rst) st <= S_IDLE;
      else st <= nxt;
   end
   always_comb begin
      nxt = st;
      bnn_en_o = 1'b0;
      bnn_operator_o = 3'd0;
      bnn_addr_o = 32'd0;
      bnn_data_o = 32'd0;
      unique case (st)
         S_IDLE: nxt = start_ok ? S_INI : S_IDLE;
         S_INI: begin
            bnn_en_o = !zero;
            nxt = zero ? S_FIN : (bnn_ready_i ? S_ACC : S_INI);
         end
         S_ACC: begin
            bnn_en_o = 1'b1;
            bnn_operator_o = 3'd1;
            bnn_addr_o = {16'd0, acc_addr};
            bnn_data_o = mem[rd_addr];
            nxt = bnn_ready_i && last_w ? S_POOL : S_ACC;
         end
         S_POOL: begin
            bnn_en_o = 1'b1;
            bnn_operator_o = 3'd2;
            nxt = bnn_ready_i ? (last_p ? S_NORM : S_ACC) : S_POOL;
         end
         S_NORM: begin
            bnn_en_o = 1'b1;
            bnn_operator_o = 3'd3;
            bnn_addr_o = {16'd0, nb_q + {8'd0, b_q}};
            nxt = bnn_ready_i ? S_ACTIV : S_NORM;
         end
         S_ACTIV: begin
            bnn_en_o = 1'b1;
            bnn_operator_o = 3'd4;
            nxt = bnn_ready_i ? S_WAITR : S_ACTIV;
         end
         S_WAITR: nxt = cap ? (last_b ? S_FIN : S_INI) : S_WAITR;
         S_FIN: nxt = start_ok ? S_INI : S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         w_n <= 8'd0;
         p_n <= 4'd0;
         b_n <= 8'd0;
         pb_q <= 16'd0;
         nb_q <= 16'd0;
         w_q <= 8'd0;
         p_q <= 4'd0;
         b_q <= 8'd0;
         skip_q <= 1'b0;
         res_valid_o <= 1'b0;
         res_idx_o <= 8'd0;
         res_data_o <= 32'd0;
      end else begin
         res_valid_o <= cap;
         // the coprocessor result is not valid in the cycle right after the activ transfer
         skip_q <= st == S_ACTIV && xfer;
         if (start_ok) begin
            w_n <= in_words_i;
            p_n <= pool_n_i;
            b_n <= out_blocks_i;
            pb_q <= param_base_i;
            nb_q <= norm_base_i;
            b_q <= 8'd0;
         end
         if (st == S_INI) begin
            w_q <= 8'd0;
            p_q <= 4'd0;
         end
         if (st == S_ACC && xfer) w_q <= last_w ? 8'd0 : w_q + 8'd1;
         if (st == S_POOL && xfer) p_q <= p_q + 4'd1;
         if (cap) begin
            res_data_o <= bnn_result_i;
            res_idx_o <= b_q;
            b_q <= b_q + 8'd1;
         end
      end
   end
`ifdef BNN_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         perf_cycles_o <= 32'd0;
         perf_stall_o <= 32'd0;
      end else begin
         if (busy_o && perf_cycles_o != 32'hFFFF_FFFF) perf_cycles_o <= perf_cycles_o + 32'd1;
         if (((bnn_en_o && !bnn_ready_i) || st == S_WAITR) && perf_stall_o != 32'hFFFF_FFFF)
            perf_stall_o <= perf_stall_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_zeroriscy_bnn_seq.sv
// tb_zeroriscy_bnn_seq: scoreboard bench; expected commands/results are queued at start and
// popped as the DUT transfers commands and emits activation words.
module tb_zeroriscy_bnn_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, in_we_i, start_i, busy_o, done_o, res_valid_o, bnn_en_o, bnn_ready_i;
   logic [5:0] in_waddr_i;
   logic [31:0] in_wdata_i, res_data_o, bnn_addr_o, bnn_data_o, bnn_result_i;
   logic [7:0] in_words_i, out_blocks_i, res_idx_o;
   logic [3:0] pool_n_i;
   logic [15:0] param_base_i, norm_base_i;
   logic [2:0] bnn_operator_o;
`ifdef BNN_SEQ_PERF_EN
   logic [31:0] perf_cycles_o, perf_stall_o;
`endif
   zeroriscy_bnn_seq dut (
      .clk(clk), .rst(rst), .in_we_i(in_we_i), .in_waddr_i(in_waddr_i), .in_wdata_i(in_wdata_i),
      .start_i(start_i), .in_words_i(in_words_i), .pool_n_i(pool_n_i), .out_blocks_i(out_blocks_i),
      .param_base_i(param_base_i), .norm_base_i(norm_base_i), .busy_o(busy_o), .done_o(done_o),
      .res_valid_o(res_valid_o), .res_idx_o(res_idx_o), .res_data_o(res_data_o),
      .bnn_en_o(bnn_en_o), .bnn_operator_o(bnn_operator_o), .bnn_addr_o(bnn_addr_o),
      .bnn_data_o(bnn_data_o), .bnn_result_i(bnn_result_i), .bnn_ready_i(bnn_ready_i)
`ifdef BNN_SEQ_PERF_EN
      , .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o)
`endif
   );
   logic [31:0] tb_mem [64];
   logic [66:0] cmd_q [$];
   logic [39:0] res_q [$];
   int errors = 0, checks = 0, done_cnt = 0, res_cnt = 0, acc_seen = 0;
   int stall_left = 0, wait_low = 0, wk = 0, d0;
   bit act_seen = 0, in_wait = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_res(input int b);
      return 32'hDEADBEEF + 32'(b) * 32'h0101_0101;
   endfunction

   always @(negedge clk) begin
      if (bnn_en_o && bnn_ready_i) begin
         if (cmd_q.size() == 0) check("cmd_unexpected", 96'(cmd_q.size()), 96'd1);
         else check("cmd", {bnn_operator_o, bnn_addr_o, bnn_data_o}, cmd_q.pop_front());
         if (bnn_operator_o == 3'd1) acc_seen++;
         if (bnn_operator_o == 3'd4) act_seen = 1;
      end
      if (res_valid_o) begin
         if (res_q.size() == 0) check("res_unexpected", 96'(res_q.size()), 96'd1);
         else check("res", {res_idx_o, res_data_o}, res_q.pop_front());
         res_cnt++;
      end
      if (done_o) done_cnt++;
   end

   // coprocessor model: drives ready/result for the cycle that starts at this posedge
   task automatic cycle();
      @(posedge clk);
      #1;
      if (act_seen) begin
         act_seen = 0;
         in_wait = 1;
         wk = 0;
      end
      if (res_valid_o) in_wait = 0;
      if (in_wait) begin
         bnn_ready_i = wk >= wait_low;
         bnn_result_i = (wk >= (wait_low > 1 ? wait_low : 1)) ? model_res(res_cnt) : 32'hBAD0_0000 | 32'(wk);
         wk++;
      end else if (bnn_en_o && bnn_operator_o == 3'd1 && acc_seen == 1 && stall_left > 0) begin
         bnn_ready_i = 1'b0;
         stall_left--;
         check("stall_hold", {bnn_en_o, bnn_operator_o, bnn_addr_o, bnn_data_o}, {1'b1, cmd_q[0]});
      end else begin
         bnn_ready_i = 1'b1;
         bnn_result_i = 32'h0;
      end
   endtask

   task automatic build(input int w, input int p, input int nb_blk, input logic [15:0] pb, input logic [15:0] nb);
      logic [15:0] a;
      for (int b = 0; b < nb_blk; b++) begin
         cmd_q.push_back({3'd0, 64'd0});
         for (int pp = 0; pp < p; pp++) begin
            for (int ww = 0; ww < w; ww++) begin
               a = pb + 16'(b * w + ww);
               cmd_q.push_back({3'd1, 16'd0, a, tb_mem[(pp * w + ww) % 64]});
            end
            cmd_q.push_back({3'd2, 64'd0});
         end
         a = nb + 16'(b);
         cmd_q.push_back({3'd3, 16'd0, a, 32'd0});
         cmd_q.push_back({3'd4, 64'd0});
         res_q.push_back({8'(b), model_res(b)});
      end
   endtask

   task automatic start_layer(input int w, input int p, input int b, input logic [15:0] pb, input logic [15:0] nb);
      acc_seen = 0;
      res_cnt = 0;
      in_words_i = 8'(w);
      pool_n_i = 4'(p);
      out_blocks_i = 8'(b);
      param_base_i = pb;
      norm_base_i = nb;
      start_i = 1'b1;
      cycle();
      start_i = 1'b0;
      in_words_i = 8'h5;
      pool_n_i = 4'h3;
      out_blocks_i = 8'h7;
      param_base_i = 16'h1234;
      norm_base_i = 16'h4321;
   endtask

   task automatic run_layer(input int w, input int p, input int b, input logic [15:0] pb, input logic [15:0] nb,
                            input int stall, input int wl, input bit poke);
      build(w, p, b, pb, nb);
      stall_left = stall;
      wait_low = wl;
      d0 = done_cnt;
      start_layer(w, p, b, pb, nb);
      check("busy_start", 96'(busy_o), 96'd1);
      for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
         if (poke && i == 4) start_i = 1'b1;
         cycle();
         start_i = 1'b0;
      end
      check("done_pulses", 96'(done_cnt - d0), 96'd1);
      check("cmd_left", 96'(cmd_q.size()), 96'd0);
      check("res_count", 96'(res_cnt), 96'(b));
      check("busy_after", 96'(busy_o), 96'd0);
      cmd_q.delete();
      res_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      in_we_i = 1'b0;
      in_waddr_i = '0;
      in_wdata_i = '0;
      start_i = 1'b0;
      in_words_i = '0;
      pool_n_i = '0;
      out_blocks_i = '0;
      param_base_i = '0;
      norm_base_i = '0;
      bnn_ready_i = 1'b1;
      bnn_result_i = '0;
      cycle();
      cycle();
      check("rst_busy", 96'(busy_o), 96'd0);
      check("rst_done", 96'(done_o), 96'd0);
      check("rst_outs", {res_valid_o, bnn_en_o, bnn_operator_o, bnn_addr_o, bnn_data_o}, 96'd0);
      check("rst_res", {res_idx_o, res_data_o}, 96'd0);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) begin
         tb_mem[i] = i == 0 ? 32'hAAAA5555 : i == 1 ? 32'h0F0F0F0F : $urandom;
         in_we_i = 1'b1;
         in_waddr_i = 6'(i);
         in_wdata_i = tb_mem[i];
         cycle();
      end
      in_we_i = 1'b0;
      run_layer(2, 1, 1, 16'h0010, 16'h0100, 0, 0, 0);
      run_layer(1, 2, 2, 16'h0020, 16'h0200, 0, 2, 0);
      run_layer(3, 2, 1, 16'h0040, 16'h0300, 3, 0, 0);
      check("stall_used", 96'(stall_left), 96'd0);
      run_layer(2, 1, 1, 16'hFFFF, 16'h0005, 0, 0, 0);
      run_layer(2, 2, 2, 16'h0100, 16'h0700, 0, 1, 1);
      run_layer(5, 3, 3, 16'h0abc, 16'hFFFE, 2, 3, 0);
      d0 = done_cnt;
      start_layer(0, 2, 2, 16'h0010, 16'h0100);
      check("zero_busy", 96'(busy_o), 96'd1);
      check("zero_done0", 96'(done_o), 96'd0);
      cycle();
      check("zero_done1", 96'(done_o), 96'd1);
      check("zero_busy1", 96'(busy_o), 96'd0);
      cycle();
      check("zero_done_once", 96'(done_cnt - d0), 96'd1);
      build(2, 2, 2, 16'h0010, 16'h0100);
      start_layer(2, 2, 2, 16'h0010, 16'h0100);
      for (int i = 0; i < 50 && !(bnn_en_o && bnn_operator_o == 3'd1); i++) cycle();
      check("rst_in_acc", 96'(bnn_operator_o), 96'd1);
      d0 = done_cnt;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("abort_en", 96'(bnn_en_o), 96'd0);
      check("abort_busy", 96'(busy_o), 96'd0);
      cmd_q.delete();
      res_q.delete();
      repeat (5) cycle();
      check("abort_no_done", 96'(done_cnt - d0), 96'd0);
      run_layer(2, 1, 2, 16'h0010, 16'h0100, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
